control_unit: RTL and testbench
===============================

// Module: control_unit
// PURPOSE
//   Sequencer FSM of the accumulator CPU; sits directly downstream of the instruction register.
//   Consumes the latched code_op and the carry flag.
//   Drives every load/enable strobe of the datapath: PC, IR, ACC, carry, memory and address mux.
//   Multi-cycle: fetch, load IR, decode, then execute/store/jump, then back to fetch.
// PARAMETERS
//   OP_W        3   opcode width (matches IR code_op)
//   ALU_SEL_W   2   ALU function select width
//   ICNT_W      16  retired-instruction counter width
// PORTS
//   clk          in   1          system clock, rising edge
//   rst          in   1          asynchronous, active-high reset
//   ce           in   1          clock enable; FSM and counter advance only when ce=1
//   code_op      in   OP_W       opcode from instruction register
//   carry        in   1          registered carry flag from datapath
//   init_PC      out  1          clear PC to 0
//   inc_PC       out  1          PC <= PC+1
//   load_PC      out  1          PC <= ADR_RI
//   load_RI      out  1          IR <= memory data
//   sel_adr      out  1          memory address mux: 0=PC, 1=ADR_RI
//   mem_en       out  1          memory access enable (sync RAM, 1-cycle read latency)
//   mem_we       out  1          memory write (ACC -> mem[ADR_RI])
//   load_ACC     out  1          ACC <= ALU result
//   load_carry   out  1          carry <= ALU carry-out
//   clear_carry  out  1          carry <= 0
//   sel_ual      out  ALU_SEL_W  00 NOR, 01 ADD, 10 SUB, 11 PASS (operand -> ACC)
//   halted       out  1          core stopped (HALT_EN only; tied 0 otherwise)
//   instr_count  out  ICNT_W     retired-instruction count
// BEHAVIOUR
//   - Opcodes: 000 NOR, 001 ADD, 010 STA, 011 JCC, 100 LDA, 101 SUB, 110 JMP, 111 NOP/HALT.
//   - States: INIT, FETCH, LOAD_IR, DECODE, EXEC, STORE, JUMP, CLRC, HALT.
//   - Moore outputs; all strobes 0 except those listed per state.
//   - State register changes only on clk edges with ce=1; with ce=0 the state holds and outputs stay stable.
//   - INIT: init_PC=1 -> FETCH.
//   - FETCH: sel_adr=0, mem_en=1 -> LOAD_IR.
//   - LOAD_IR: load_RI=1, inc_PC=1 -> DECODE.
//   - DECODE: sel_adr=1, mem_en=1 (operand read); next state chosen from code_op:
//       NOR/ADD/SUB/LDA -> EXEC
//       STA -> STORE
//       JMP -> JUMP
//       JCC with carry=0 -> JUMP
//       JCC with carry=1 -> CLRC
//       111 -> FETCH, or HALT with HALT_EN.
//   - EXEC: load_ACC=1, sel_ual from opcode -> FETCH.
//       load_carry=1 for ADD/SUB only; NOR and LDA leave carry unchanged.
//   - STORE: sel_adr=1, mem_en=1, mem_we=1 -> FETCH.
//   - JUMP: load_PC=1 -> FETCH.
//   - CLRC: clear_carry=1 -> FETCH.
//   - instr_count increments by 1 on each ce-qualified transition back into FETCH from EXEC/STORE/JUMP/CLRC/DECODE.
//       Wraps modulo 2^ICNT_W.
//       The INIT->FETCH transition does not count.
//   - Reset (any time, mid-instruction included): state=INIT, instr_count=0.
//       All strobes 0 except init_PC=1 (INIT output); sel_ual=00; halted=0.
//   - An in-flight STORE aborted by reset issues no write after reset deassertion.
//   - Unknown/illegal state encodings recover to INIT on the next ce cycle.
// CONFIGURATION
//   - HALT_EN defined: opcode 111 in DECODE -> HALT.
//       HALT is absorbing (only rst exits), halted=1, no strobes, counter frozen.
//       The halt instruction itself is counted on entry.
//   - HALT_EN undefined: 111 is NOP (DECODE -> FETCH, counted); HALT state absent; halted tied 0.
// STRUCTURE
//   - cpu_pkg: opcode localparams (OP_NOR..OP_NOP), ALU select codes, state encoding, widths.
//   - Single module: state register + next-state logic + output decode + counter; no sub-module.
// TESTING
//   1. rst pulse mid-STORE -> next cycle state INIT, mem_we=0, init_PC=1, instr_count=0.
//   2. code_op=001, ce=1 -> FETCH,LOAD_IR,DECODE,EXEC:
//        EXEC has load_ACC=1, load_carry=1, sel_ual=01; instr_count 0->1 on return to FETCH.
//   3. code_op=011, carry=1 -> DECODE->CLRC (clear_carry=1), no load_PC.
//      Same with carry=0 -> JUMP with load_PC=1.
//   4. ce toggled 1,0,0,1 during LOAD_IR -> load_RI held high through ce=0 cycles; single advance to DECODE.
//   5. code_op=010 -> STORE cycle with sel_adr=1, mem_en=1, mem_we=1 for exactly one ce cycle.
//   6. code_op=111: with HALT_EN -> halted=1 and held for 20 cycles until rst.
//      Without HALT_EN -> back to FETCH, count+1.

Source files
------------

// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
//   Shared definitions for the accumulator CPU: default widths, opcode and
//   ALU select encodings, sequencer state encoding, and the opcode -> ALU
//   function mapping used by the control unit.
// -----------------------------------------------------------------------------
package cpu_pkg;

  localparam int CPU_OP_W      = 3;
  localparam int CPU_ALU_SEL_W = 2;
  localparam int CPU_ICNT_W    = 16;

  localparam logic [2:0] OP_NOR = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_STA = 3'b010;
  localparam logic [2:0] OP_JCC = 3'b011;
  localparam logic [2:0] OP_LDA = 3'b100;
  localparam logic [2:0] OP_SUB = 3'b101;
  localparam logic [2:0] OP_JMP = 3'b110;
  localparam logic [2:0] OP_NOP = 3'b111;

  localparam logic [1:0] ALU_NOR  = 2'b00;
  localparam logic [1:0] ALU_ADD  = 2'b01;
  localparam logic [1:0] ALU_SUB  = 2'b10;
  localparam logic [1:0] ALU_PASS = 2'b11;

  typedef enum logic [3:0] {
    S_INIT    = 4'd0,
    S_FETCH   = 4'd1,
    S_LOAD_IR = 4'd2,
    S_DECODE  = 4'd3,
    S_EXEC    = 4'd4,
    S_STORE   = 4'd5,
    S_JUMP    = 4'd6,
    S_CLRC    = 4'd7,
    S_HALT    = 4'd8
  } state_t;

  // ALU function for the arithmetic/load opcodes; LDA passes the operand.
  function automatic logic [1:0] alu_sel(input logic [2:0] op);
    case (op)
      OP_ADD:  alu_sel = ALU_ADD;
      OP_SUB:  alu_sel = ALU_SUB;
      OP_LDA:  alu_sel = ALU_PASS;
      default: alu_sel = ALU_NOR;
    endcase
  endfunction

endpackage

// File: rtl/control_unit.sv
// -----------------------------------------------------------------------------
// control_unit
//   Multi-cycle sequencer of the accumulator CPU. Walks fetch / load IR /
//   decode / execute-store-jump and drives every datapath strobe. Outputs are
//   Moore and registered: they are decoded from the next state and loaded
//   together with the state register, so they change only on ce-qualified
//   clock edges (or asynchronously to INIT values on rst).
//
//   Build option: define HALT_EN to make opcode 111 stop the core in an
//   absorbing HALT state; otherwise 111 is a NOP and halted is tied 0.
//
// Ports
//   clk, rst        clock (rising edge), async active-high reset
//   ce              clock enable for state, strobes and counter
//   code_op         latched opcode from the instruction register
//   carry           registered carry flag (JCC condition)
//   init_PC/inc_PC/load_PC        program counter controls
//   load_RI                       instruction register load
//   sel_adr, mem_en, mem_we       memory address mux / access / write
//   load_ACC, load_carry, clear_carry, sel_ual   accumulator/ALU controls
//   halted                        core stopped (HALT_EN builds only)
//   instr_count                   retired-instruction counter, wraps
//
// state     | meaning
// ----------+--------------------------------------------------------------
// S_INIT    | clear PC, entered on reset or from an illegal encoding
// S_FETCH   | read instruction at PC
// S_LOAD_IR | latch instruction, advance PC
// S_DECODE  | read operand at ADR_RI, branch on opcode
// S_EXEC    | ALU result into ACC (carry updated for ADD/SUB)
// S_STORE   | write ACC to mem[ADR_RI]
// S_JUMP    | PC <= ADR_RI
// S_CLRC    | JCC not taken: clear carry
// S_HALT    | stopped until reset (HALT_EN only)
// -----------------------------------------------------------------------------
module control_unit
  import cpu_pkg::*;
#(
  parameter int OP_W      = CPU_OP_W,
  parameter int ALU_SEL_W = CPU_ALU_SEL_W,
  parameter int ICNT_W    = CPU_ICNT_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ce,
  input  logic [OP_W-1:0]      code_op,
  input  logic                 carry,
  output logic                 init_PC,
  output logic                 inc_PC,
  output logic                 load_PC,
  output logic                 load_RI,
  output logic                 sel_adr,
  output logic                 mem_en,
  output logic                 mem_we,
  output logic                 load_ACC,
  output logic                 load_carry,
  output logic                 clear_carry,
  output logic [ALU_SEL_W-1:0] sel_ual,
  output logic                 halted,
  output logic [ICNT_W-1:0]    instr_count
);

  state_t state_q;
  state_t state_d;
  logic   count_en;

  logic                 init_pc_d, inc_pc_d, load_pc_d, load_ri_d;
  logic                 sel_adr_d, mem_en_d, mem_we_d;
  logic                 load_acc_d, load_carry_d, clear_carry_d;
  logic [ALU_SEL_W-1:0] sel_ual_d;
  logic                 halted_d;
  logic [2:0]           op3;

  assign op3 = 3'(code_op);

  always_comb begin
    state_d = S_INIT;
    case (state_q)
      S_INIT:    state_d = S_FETCH;
      S_FETCH:   state_d = S_LOAD_IR;
      S_LOAD_IR: state_d = S_DECODE;
      S_DECODE: begin
        case (op3)
          OP_NOR, OP_ADD, OP_SUB, OP_LDA: state_d = S_EXEC;
          OP_STA:  state_d = S_STORE;
          OP_JMP:  state_d = S_JUMP;
          OP_JCC:  state_d = carry ? S_CLRC : S_JUMP;
`ifdef HALT_EN
          default: state_d = S_HALT;
`else
          default: state_d = S_FETCH;
`endif
        endcase
      end
      S_EXEC, S_STORE, S_JUMP, S_CLRC: state_d = S_FETCH;
`ifdef HALT_EN
      S_HALT:    state_d = S_HALT;
`endif
      default:   state_d = S_INIT;
    endcase
  end

  // Every instruction retires on its way back to FETCH (or into HALT); the
  // start-up INIT->FETCH step and the HALT self-loop are not instructions.
  assign count_en = ((state_d == S_FETCH) || (state_d == S_HALT)) &&
                    (state_q != S_INIT) && (state_q != S_HALT);

  // Output decode of the state about to be entered.
  always_comb begin
    init_pc_d     = 1'b0;
    inc_pc_d      = 1'b0;
    load_pc_d     = 1'b0;
    load_ri_d     = 1'b0;
    sel_adr_d     = 1'b0;
    mem_en_d      = 1'b0;
    mem_we_d      = 1'b0;
    load_acc_d    = 1'b0;
    load_carry_d  = 1'b0;
    clear_carry_d = 1'b0;
    sel_ual_d     = '0;
    halted_d      = 1'b0;
    case (state_d)
      S_INIT:    init_pc_d = 1'b1;
      S_FETCH:   mem_en_d  = 1'b1;
      S_LOAD_IR: begin
        load_ri_d = 1'b1;
        inc_pc_d  = 1'b1;
      end
      S_DECODE: begin
        sel_adr_d = 1'b1;
        mem_en_d  = 1'b1;
      end
      S_EXEC: begin
        // code_op is the IR contents, stable through the whole instruction.
        load_acc_d   = 1'b1;
        sel_ual_d    = ALU_SEL_W'(alu_sel(op3));
        load_carry_d = (op3 == OP_ADD) || (op3 == OP_SUB);
      end
      S_STORE: begin
        sel_adr_d = 1'b1;
        mem_en_d  = 1'b1;
        mem_we_d  = 1'b1;
      end
      S_JUMP:    load_pc_d     = 1'b1;
      S_CLRC:    clear_carry_d = 1'b1;
      S_HALT:    halted_d      = 1'b1;
      default:   ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_INIT;
      instr_count <= '0;
      init_PC     <= 1'b1;
      inc_PC      <= 1'b0;
      load_PC     <= 1'b0;
      load_RI     <= 1'b0;
      sel_adr     <= 1'b0;
      mem_en      <= 1'b0;
      mem_we      <= 1'b0;
      load_ACC    <= 1'b0;
      load_carry  <= 1'b0;
      clear_carry <= 1'b0;
      sel_ual     <= '0;
    end else if (ce) begin
      state_q     <= state_d;
      if (count_en) instr_count <= instr_count + ICNT_W'(1);
      init_PC     <= init_pc_d;
      inc_PC      <= inc_pc_d;
      load_PC     <= load_pc_d;
      load_RI     <= load_ri_d;
      sel_adr     <= sel_adr_d;
      mem_en      <= mem_en_d;
      mem_we      <= mem_we_d;
      load_ACC    <= load_acc_d;
      load_carry  <= load_carry_d;
      clear_carry <= clear_carry_d;
      sel_ual     <= sel_ual_d;
    end
  end

`ifdef HALT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     halted <= 1'b0;
    else if (ce) halted <= halted_d;
  end
`else
  assign halted = 1'b0;
  logic unused_halt;
  assign unused_halt = halted_d;
`endif

endmodule

// File: tb/tb_control_unit.sv
// -----------------------------------------------------------------------------
// tb_control_unit
//   Directed bench for the sequencer. Outputs are packed into one vector
//   {init_PC,inc_PC,load_PC,load_RI,sel_adr,mem_en,mem_we,load_ACC,
//    load_carry,clear_carry,sel_ual[1:0],halted} and compared at the falling
//   edge against hand-written per-state values; instr_count against a
//   running expected count.
// -----------------------------------------------------------------------------
module tb_control_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ce  = 1'b1;
  logic [2:0]  code_op = 3'b000;
  logic        carry = 1'b0;
  logic        init_PC, inc_PC, load_PC, load_RI, sel_adr, mem_en, mem_we;
  logic        load_ACC, load_carry, clear_carry, halted;
  logic [1:0]  sel_ual;
  logic [15:0] instr_count;

  int n_chk  = 0;
  int n_fail = 0;
  int exp_cnt = 0;

  localparam logic [12:0] V_INIT  = 13'b1_0_0_0_0_0_0_0_0_0_00_0;
  localparam logic [12:0] V_FETCH = 13'b0_0_0_0_0_1_0_0_0_0_00_0;
  localparam logic [12:0] V_LDIR  = 13'b0_1_0_1_0_0_0_0_0_0_00_0;
  localparam logic [12:0] V_DEC   = 13'b0_0_0_0_1_1_0_0_0_0_00_0;
  localparam logic [12:0] V_ADD   = 13'b0_0_0_0_0_0_0_1_1_0_01_0;
  localparam logic [12:0] V_SUB   = 13'b0_0_0_0_0_0_0_1_1_0_10_0;
  localparam logic [12:0] V_NOR   = 13'b0_0_0_0_0_0_0_1_0_0_00_0;
  localparam logic [12:0] V_LDA   = 13'b0_0_0_0_0_0_0_1_0_0_11_0;
  localparam logic [12:0] V_STORE = 13'b0_0_0_0_1_1_1_0_0_0_00_0;
  localparam logic [12:0] V_JUMP  = 13'b0_0_1_0_0_0_0_0_0_0_00_0;
  localparam logic [12:0] V_CLRC  = 13'b0_0_0_0_0_0_0_0_0_1_00_0;
  localparam logic [12:0] V_HALT  = 13'b0_0_0_0_0_0_0_0_0_0_00_1;

  logic [12:0] outs;
  assign outs = {init_PC, inc_PC, load_PC, load_RI, sel_adr, mem_en, mem_we,
                 load_ACC, load_carry, clear_carry, sel_ual, halted};

  control_unit dut (
    .clk(clk), .rst(rst), .ce(ce), .code_op(code_op), .carry(carry),
    .init_PC(init_PC), .inc_PC(inc_PC), .load_PC(load_PC), .load_RI(load_RI),
    .sel_adr(sel_adr), .mem_en(mem_en), .mem_we(mem_we), .load_ACC(load_ACC),
    .load_carry(load_carry), .clear_carry(clear_carry), .sel_ual(sel_ual),
    .halted(halted), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Starts with the DUT sitting in FETCH; ends back in FETCH (or HALT).
  task automatic run_instr(input string tag, input logic [2:0] op, input logic c,
                           input int stall, input bit has_exec,
                           input logic [12:0] exec_vec);
    code_op = op;
    carry   = c;
    @(negedge clk);
    chk({tag, "_ldir"}, 32'(outs), 32'(V_LDIR));
    if (stall > 0) begin
      ce = 1'b0;
      for (int i = 0; i < stall; i++) begin
        @(negedge clk);
        chk({tag, "_ldir_hold"}, 32'(outs), 32'(V_LDIR));
      end
      ce = 1'b1;
    end
    @(negedge clk);
    chk({tag, "_dec"}, 32'(outs), 32'(V_DEC));
    if (has_exec) begin
      @(negedge clk);
      chk({tag, "_exec"}, 32'(outs), 32'(exec_vec));
      chk({tag, "_cnt_pre"}, 32'(instr_count), 32'(exp_cnt));
    end
    @(negedge clk);
    exp_cnt++;
    chk({tag, "_cnt"}, 32'(instr_count), 32'(exp_cnt));
  endtask

  initial begin
    // Reset state
    @(negedge clk);
    chk("rst_outs", 32'(outs), 32'(V_INIT));
    chk("rst_cnt", 32'(instr_count), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("init_fetch", 32'(outs), 32'(V_FETCH));
    chk("init_nocount", 32'(instr_count), 32'd0);

    run_instr("add", 3'b001, 1'b0, 0, 1'b1, V_ADD);
    chk("add_fetch", 32'(outs), 32'(V_FETCH));
    run_instr("jcc_c1", 3'b011, 1'b1, 0, 1'b1, V_CLRC);
    run_instr("jcc_c0", 3'b011, 1'b0, 0, 1'b1, V_JUMP);
    run_instr("sta", 3'b010, 1'b0, 0, 1'b1, V_STORE);
    chk("sta_one_cycle", 32'(outs), 32'(V_FETCH));
    run_instr("nor", 3'b000, 1'b1, 0, 1'b1, V_NOR);
    run_instr("sub", 3'b101, 1'b0, 0, 1'b1, V_SUB);
    run_instr("lda", 3'b100, 1'b0, 0, 1'b1, V_LDA);
    run_instr("jmp", 3'b110, 1'b1, 0, 1'b1, V_JUMP);
    run_instr("stall", 3'b001, 1'b0, 2, 1'b1, V_ADD);

`ifdef HALT_EN
    code_op = 3'b111;
    @(negedge clk); chk("hlt_ldir", 32'(outs), 32'(V_LDIR));
    @(negedge clk); chk("hlt_dec", 32'(outs), 32'(V_DEC));
    @(negedge clk);
    exp_cnt++;
    chk("hlt_enter", 32'(outs), 32'(V_HALT));
    chk("hlt_cnt", 32'(instr_count), 32'(exp_cnt));
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("hlt_hold", 32'(outs), 32'(V_HALT));
    end
    chk("hlt_frozen", 32'(instr_count), 32'(exp_cnt));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_cnt = 0;
    chk("hlt_rst", 32'(outs), 32'(V_INIT));
    @(negedge clk);
    chk("hlt_rst_fetch", 32'(outs), 32'(V_FETCH));
`else
    run_instr("nop", 3'b111, 1'b0, 0, 1'b0, V_FETCH);
    chk("nop_fetch", 32'(outs), 32'(V_FETCH));
`endif

    // Reset in the middle of a STORE
    code_op = 3'b010;
    @(negedge clk); chk("mid_ldir", 32'(outs), 32'(V_LDIR));
    @(negedge clk); chk("mid_dec", 32'(outs), 32'(V_DEC));
    @(negedge clk); chk("mid_store", 32'(outs), 32'(V_STORE));
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_async", 32'(outs), 32'(V_INIT));
    @(negedge clk);
    rst = 1'b0;
    exp_cnt = 0;
    chk("mid_rst_outs", 32'(outs), 32'(V_INIT));
    chk("mid_rst_we", 32'(mem_we), 32'd0);
    chk("mid_rst_cnt", 32'(instr_count), 32'd0);
    @(negedge clk);
    chk("mid_rst_fetch", 32'(outs), 32'(V_FETCH));
    chk("mid_rst_cnt2", 32'(instr_count), 32'd0);
    run_instr("post_rst", 3'b100, 1'b0, 0, 1'b1, V_LDA);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
